// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: fetches sequential ROM words into a small circular
// buffer ahead of decode, with flush-and-refetch on redirect.
module instr_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  output logic [7:0]               rom_address,
  input  logic [31:0]              rom_data,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     ready,
  output logic                     valid,
  output logic [31:0]              instr,
  output logic [31:0]              pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count_q;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          pop, push;

  // Handshake: an entry transfers to decode on a rising edge where valid && ready;
  // valid never depends on ready, and a redirect in the same cycle cancels the transfer.
  assign valid = (count_q != '0);
  assign pop   = valid && ready && !redirect;
  // A pop in the same cycle frees a slot, so a full queue can still accept a push.
  assign push  = enable && !redirect && ((count_q < DEPTH_C) || pop);

  assign rom_address = fetch_pc[9:2];
  assign count       = count_q;
  assign instr       = valid ? instr_mem[head] : 32'h0;
  assign pc          = valid ? pc_mem[head]    : 32'h0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'd3;
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        tail     <= tail + PW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Storage is not reset; outputs are masked while the queue is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= rom_data;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_instr_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  rom_address;
  logic [31:0] rom_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready = 1'b0;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [$clog2(DEPTH):0] count;

  int vectors = 0;
  int miscompares = 0;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .enable(enable), .rom_address(rom_address),
    .rom_data(rom_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .ready(ready), .valid(valid), .instr(instr), .pc(pc), .count(count)
  );

  // Clock / ROM
  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [7:0] idx);
    return 32'h1000_0000 + {24'h0, idx};
  endfunction

  assign rom_data = rom_word(rom_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected queue of {pc, instr} and the next fetch address
  logic [63:0] exp_q[$];
  logic [31:0] m_fpc = RESET_PC;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_fpc = RESET_PC;
    end else if (redirect) begin
      exp_q.delete();
      m_fpc = {redirect_pc[31:2], 2'b00};
    end else begin
      automatic bit do_pop  = (exp_q.size() != 0) && ready;
      automatic bit do_push = enable && ((exp_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back({m_fpc, rom_word(m_fpc[9:2])});
        m_fpc = m_fpc + 32'd4;
      end
    end
  end

  // Per-cycle comparison against the model
  always begin
    @(posedge clock);
    #2;
    check("model_valid", {31'h0, valid}, {31'h0, exp_q.size() != 0});
    check("model_count", 32'(count), 32'(exp_q.size()));
    check("model_pc", pc, (exp_q.size() != 0) ? exp_q[0][63:32] : 32'h0);
    check("model_instr", instr, (exp_q.size() != 0) ? exp_q[0][31:0] : 32'h0);
    check("model_rom_address", {24'h0, rom_address}, {24'h0, m_fpc[9:2]});
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  logic [31:0] rdy_pat = 32'hA5C3_0F96;
  logic [31:0] en_pat  = 32'hF7BD_EF3F;

  initial begin
    #1 reset = 1'b0;
    #1;
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_count", 32'(count), 32'h0);
    check("reset_pc", pc, 32'h0);
    check("reset_instr", instr, 32'h0);
    check("reset_rom_address", {24'h0, rom_address}, 32'h0);

    // Fill: six cycles, enable, no ready
    @(negedge clock);
    reset = 1'b1; enable = 1'b1; ready = 1'b0;
    cycles(6);
    check("fill_count", 32'(count), 32'd4);
    check("fill_pc", pc, 32'h0);
    check("fill_instr", instr, 32'h1000_0000);
    check("fill_rom_address", {24'h0, rom_address}, 32'd4);

    // Full + pop for one cycle
    ready = 1'b1;
    cycles(1);
    ready = 1'b0;
    check("fullpop_count", 32'(count), 32'd4);
    check("fullpop_pc", pc, 32'h4);
    check("fullpop_instr", instr, 32'h1000_0001);
    check("fullpop_rom_address", {24'h0, rom_address}, 32'd5);

    // Redirect to unaligned 0x41
    redirect = 1'b1; redirect_pc = 32'h41;
    cycles(1);
    redirect = 1'b0;
    check("redir_count", 32'(count), 32'd0);
    check("redir_valid", {31'h0, valid}, 32'h0);
    cycles(1);
    check("redir_first_valid", {31'h0, valid}, 32'h1);
    check("redir_first_pc", pc, 32'h40);
    check("redir_first_instr", instr, 32'h1000_0010);

    // Streaming from reset with ready held high
    ready = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycles(1);
      check("stream_pc", pc, 32'(4 * k));
      check("stream_instr", instr, 32'h1000_0000 + 32'(k));
      check("stream_count", 32'(count), 32'd1);
    end

    // Reset mid-fetch with three entries queued
    ready = 1'b0;
    do_reset();
    cycles(3);
    check("midrst_pre_count", 32'(count), 32'd3);
    reset = 1'b0;
    #1;
    check("midrst_valid", {31'h0, valid}, 32'h0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_pc", pc, 32'h0);
    cycles(1);
    reset = 1'b1;
    cycles(1);
    check("midrst_first_pc", pc, RESET_PC);
    check("midrst_first_count", 32'(count), 32'd1);

    // ROM address wrap at 0x3FC -> 0x400, then drain with enable low
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h3FC;
    cycles(1);
    redirect = 1'b0;
    check("wrap_rom_address_255", {24'h0, rom_address}, 32'd255);
    cycles(1);
    check("wrap_pc_3fc", pc, 32'h3FC);
    check("wrap_instr_3fc", instr, 32'h1000_00FF);
    check("wrap_rom_address_0", {24'h0, rom_address}, 32'd0);
    cycles(1);
    check("wrap_pc_400", pc, 32'h400);
    check("wrap_instr_400", instr, 32'h1000_0000);
    enable = 1'b0;
    cycles(3);
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", {31'h0, valid}, 32'h0);
    check("drain_rom_address", {24'h0, rom_address}, 32'd1);

    // fetch_pc wrap from the top of the address space
    enable = 1'b1; ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    cycles(1);
    redirect = 1'b0;
    cycles(2);
    check("pcwrap_head_pc", pc, 32'hFFFF_FFFC);
    check("pcwrap_count", 32'(count), 32'd2);
    check("pcwrap_rom_address", {24'h0, rom_address}, 32'd1);

    // Mixed enable/ready patterns, with one redirect partway through
    for (int i = 0; i < 32; i++) begin
      ready    = rdy_pat[i];
      enable   = en_pat[i];
      redirect = (i == 20);
      redirect_pc = 32'h0000_0080;
      cycles(1);
    end
    redirect = 1'b0;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #20000;
    miscompares++;
    $display("FAIL watchdog: simulation time %0t, expected completion before 20000", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-003 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have: enable  in  1  fetch permitted when high.
REQ-006 SHALL have: rom_address  out  8  ROM word index.
REQ-007 SHALL have: rom_data  in  32  ROM word at rom_address, combinational, same cycle.
REQ-008 SHALL have: redirect  in  1  branch/jump taken, flush and refetch.
REQ-009 SHALL have: redirect_pc  in  32  new byte PC on redirect.
REQ-010 SHALL have: ready  in  1  decode consumes head entry this cycle.
REQ-011 SHALL have: valid  out  1  head entry present.
REQ-012 SHALL have: instr  out  32  head instruction word.
REQ-013 SHALL have: pc  out  32  byte PC of head instruction.
REQ-014 SHALL have: count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL keep a 32-bit fetch_pc register; rom_address = fetch_pc[9:2], combinational.
REQ-016 SHALL keep a circular queue of DEPTH entries {pc, instr} with head pointer, tail pointer and count.
REQ-017 SHALL drive valid = (count != 0); instr/pc = head entry, 0 when empty.
REQ-018 pop SHALL occur when valid && ready && !redirect; head advances mod DEPTH.
REQ-019 push SHALL occur when enable && !redirect && (count < DEPTH || pop); writes {fetch_pc, rom_data} at tail; fetch_pc += 4.
REQ-020 Simultaneous push and pop when full SHALL keep count at DEPTH and lose no entry.
REQ-021 Simultaneous push and pop otherwise SHALL leave count unchanged.
REQ-022 When full with no pop, SHALL hold fetch_pc and write nothing (stall).
REQ-023 When enable low, SHALL not push; pops still proceed.
REQ-024 redirect SHALL take priority: count, head, tail <= 0; fetch_pc <= {redirect_pc[31:2], 2'b00}; no push or pop that cycle.
REQ-025 First instruction at redirect target SHALL be valid at output exactly 1 cycle after the redirect edge (if enable high), i.e. 2-cycle redirect-to-issue latency.
REQ-026 fetch_pc SHALL wrap 32'hFFFF_FFFC -> 0; rom_address wraps 255 -> 0 naturally.
REQ-027 ready while empty SHALL have no effect (no underflow).
REQ-028 Pointer arithmetic SHALL use $clog2(DEPTH) bits with natural wrap; count never exceeds DEPTH.

Reset
REQ-029 reset low SHALL immediately (asynchronously) set fetch_pc=RESET_PC, count=0, head=tail=0, valid=0, instr=0, pc=0.
REQ-030 reset low mid-operation SHALL discard all queued entries; first push after release occurs on the first rising edge with reset high and enable high.
REQ-031 Queue storage need not be cleared by reset; outputs SHALL be masked while empty.

Verification
REQ-032 Fill: ROM[i]=32'h1000_0000+i, enable=1, ready=0, 6 cycles -> count=4, fetch_pc=0x10, head pc=0, instr=32'h1000_0000; no further pushes.
REQ-033 Streaming: ready=1 continuously from reset -> one instruction per cycle, pc 0,4,8,... in order, instr matching ROM, count stays 1.
REQ-034 Full+pop: queue full, ready=1 one cycle -> count stays 4, entry pc=0x10 appended, head pc=4.
REQ-035 Redirect: queue holds pc 0..0xC, pulse redirect with redirect_pc=0x41 -> next cycle count=0, valid=0; following cycle valid=1, pc=0x40, instr=ROM[16].
REQ-036 Reset mid-fetch: count=3, drop reset between edges -> valid=0, count=0 immediately; after release, first output pc=RESET_PC.
REQ-037 Wrap: redirect_pc=0x3FC, ready=1 -> pcs 0x3FC, 0x400 with rom_address 255 then 0; enable low 3 cycles -> no new pushes, queue drains to count=0.
